// File: rtl/multicycle_ctrl_if.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_if
// Bundle of every signal exchanged between the multi-cycle control FSM and the
// shared RV32I datapath (IR, immediate extender, ALU, register file, PC and the
// single memory port).
//   master : the controller - drives strobes/selects, samples inst, br_flag,
//            mem_ready.
//   slave  : the datapath   - drives inst, br_flag, mem_ready, samples the rest.
// Signals:
//   inst[31:0]    current IR contents
//   br_flag       ALU compare result (1 = branch taken)
//   mem_ready     memory completes the current access this cycle
//   mem_req/mem_we/mem_sel_data   memory request, write, address select
//   ir_we/pc_we/rf_we             IR, PC and register-file write strobes
//   npc_op[1:0]   next-PC select      wb_sel[1:0]  write-back source
//   sext_op[2:0]  immediate format    alu_src_a/b, alu_cls[1:0] ALU control
//   halted        stopped on illegal instruction
//   state[2:0]    FSM state
// -----------------------------------------------------------------------------
interface multicycle_ctrl_if;
    logic [31:0] inst;
    logic        br_flag;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        mem_sel_data;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  npc_op;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic [2:0]  sext_op;
    logic        alu_src_a;
    logic        alu_src_b;
    logic [1:0]  alu_cls;
    logic        halted;
    logic [2:0]  state;

    modport master (
        input  inst, br_flag, mem_ready,
        output mem_req, mem_we, mem_sel_data, ir_we, pc_we, npc_op, rf_we,
               wb_sel, sext_op, alu_src_a, alu_src_b, alu_cls, halted, state
    );

    modport slave (
        output inst, br_flag, mem_ready,
        input  mem_req, mem_we, mem_sel_data, ir_we, pc_we, npc_op, rf_we,
               wb_sel, sext_op, alu_src_a, alu_src_b, alu_cls, halted, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Multi-cycle RV32I control FSM. Sequences FETCH -> DECODE -> EXEC -> (MEM) ->
// (WB) for one instruction at a time over a shared datapath with one memory
// port. Illegal opcodes park the core in HALT until reset.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   ctrl  multicycle_ctrl_if.master (datapath handshake, strobes, selects)
// Immediate format codes: I=0, SHIFT=1, S=2, U=3, B=4, J=5.
// -----------------------------------------------------------------------------
module multicycle_ctrl (
    input  logic               clk,
    input  logic               rst,
    multicycle_ctrl_if.master  ctrl
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [2:0] IMM_I     = 3'd0;
    localparam logic [2:0] IMM_SHIFT = 3'd1;
    localparam logic [2:0] IMM_S     = 3'd2;
    localparam logic [2:0] IMM_U     = 3'd3;
    localparam logic [2:0] IMM_B     = 3'd4;
    localparam logic [2:0] IMM_J     = 3'd5;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;

    localparam logic [1:0] CLS_ADD   = 2'd0;
    localparam logic [1:0] CLS_FUNCT = 2'd1;
    localparam logic [1:0] CLS_CMP   = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    logic [2:0] state_q, state_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd;
    assign opcode = ctrl.inst[6:0];
    assign funct3 = ctrl.inst[14:12];
    assign rd     = ctrl.inst[11:7];

    // Instruction decode (pure function of the IR)
    logic       dec_legal;
    logic [2:0] dec_sext;
    logic       dec_a, dec_b;
    logic [1:0] dec_cls, dec_wb;

    always_comb begin
        dec_legal = 1'b1;
        dec_sext  = IMM_I;
        dec_a     = 1'b0;
        dec_b     = 1'b0;
        dec_cls   = CLS_ADD;
        dec_wb    = WB_ALU;
        case (opcode)
            OP_R:      dec_cls = CLS_FUNCT;
            OP_IMM: begin
                dec_sext = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_SHIFT : IMM_I;
                dec_b    = 1'b1;
                dec_cls  = CLS_FUNCT;
            end
            OP_LOAD: begin
                dec_b  = 1'b1;
                dec_wb = WB_MEM;
            end
            OP_STORE: begin
                dec_sext = IMM_S;
                dec_b    = 1'b1;
            end
            OP_BRANCH: begin
                dec_sext = IMM_B;
                dec_cls  = CLS_CMP;
            end
            OP_JAL: begin
                dec_sext = IMM_J;
                dec_a    = 1'b1;
                dec_b    = 1'b1;
                dec_wb   = WB_PC4;
            end
            OP_JALR: begin
                dec_b  = 1'b1;
                dec_wb = WB_PC4;
            end
            OP_LUI: begin
                dec_sext = IMM_U;
                dec_b    = 1'b1;
                dec_wb   = WB_IMM;
            end
            OP_AUIPC: begin
                dec_sext = IMM_U;
                dec_a    = 1'b1;
                dec_b    = 1'b1;
            end
            default:   dec_legal = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (ctrl.mem_ready) state_d = S_DECODE;
            S_DECODE: state_d = dec_legal ? S_EXEC : S_HALT;
            S_EXEC: begin
                if (opcode == OP_LOAD || opcode == OP_STORE) state_d = S_MEM;
                else if (opcode == OP_BRANCH)                state_d = S_FETCH;
                else                                         state_d = S_WB;
            end
            S_MEM: begin
                if (ctrl.mem_ready) state_d = (opcode == OP_STORE) ? S_FETCH : S_WB;
            end
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Output logic. While rst is high every output is forced idle, so an
    // access interrupted by reset is dropped without waiting for the edge.
    always_comb begin
        ctrl.mem_req      = 1'b0;
        ctrl.mem_we       = 1'b0;
        ctrl.mem_sel_data = 1'b0;
        ctrl.ir_we        = 1'b0;
        ctrl.pc_we        = 1'b0;
        ctrl.npc_op       = 2'd0;
        ctrl.rf_we        = 1'b0;
        ctrl.wb_sel       = 2'd0;
        ctrl.sext_op      = 3'd0;
        ctrl.alu_src_a    = 1'b0;
        ctrl.alu_src_b    = 1'b0;
        ctrl.alu_cls      = 2'd0;
        ctrl.halted       = 1'b0;
        ctrl.state        = state_q;
        if (!rst) begin
            // Decoded selects are held stable for the whole instruction body
            if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
                ctrl.sext_op   = dec_sext;
                ctrl.alu_src_a = dec_a;
                ctrl.alu_src_b = dec_b;
                ctrl.alu_cls   = dec_cls;
                ctrl.wb_sel    = dec_wb;
            end
            case (state_q)
                S_FETCH: begin
                    ctrl.mem_req = 1'b1;
                    ctrl.ir_we   = ctrl.mem_ready;
                end
                S_EXEC: begin
                    if (opcode == OP_BRANCH) begin
                        ctrl.pc_we  = 1'b1;
                        ctrl.npc_op = ctrl.br_flag ? 2'd1 : 2'd0;
                    end
                end
                S_MEM: begin
                    ctrl.mem_req      = 1'b1;
                    ctrl.mem_sel_data = 1'b1;
                    ctrl.mem_we       = (opcode == OP_STORE);
                    ctrl.pc_we        = (opcode == OP_STORE) && ctrl.mem_ready;
                end
                S_WB: begin
                    ctrl.pc_we  = 1'b1;
                    ctrl.npc_op = (opcode == OP_JAL)  ? 2'd2 :
                                  (opcode == OP_JALR) ? 2'd3 : 2'd0;
                    ctrl.rf_we  = (rd != 5'd0);
                end
                S_HALT:  ctrl.halted = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Builds, per instruction, the expected cycle-by-cycle trace (inputs to drive
// and outputs to expect) from the instruction class and the chosen memory wait
// counts, then replays it against the controller and compares every cycle.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;
    typedef struct packed {
        logic [2:0] state;
        logic       mem_req;
        logic       mem_we;
        logic       mem_sel_data;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] npc_op;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic [2:0] sext_op;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [1:0] alu_cls;
        logic       halted;
    } exp_t;

    typedef struct {
        exp_t e;
        logic rdy;
        logic br;
    } cyc_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus();
    multicycle_ctrl dut (.clk(clk), .rst(rst), .ctrl(bus));

    int checks = 0;
    int errors = 0;
    cyc_t trace[$];

    function automatic exp_t observe();
        exp_t o;
        o.state        = bus.state;
        o.mem_req      = bus.mem_req;
        o.mem_we       = bus.mem_we;
        o.mem_sel_data = bus.mem_sel_data;
        o.ir_we        = bus.ir_we;
        o.pc_we        = bus.pc_we;
        o.npc_op       = bus.npc_op;
        o.rf_we        = bus.rf_we;
        o.wb_sel       = bus.wb_sel;
        o.sext_op      = bus.sext_op;
        o.alu_src_a    = bus.alu_src_a;
        o.alu_src_b    = bus.alu_src_b;
        o.alu_cls      = bus.alu_cls;
        o.halted       = bus.halted;
        return o;
    endfunction

    task automatic check_vec(input string name, input exp_t act, input exp_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h (state %0d) required %h (state %0d)",
                     name, act, act.state, exp, exp.state);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Instruction-class table: selects that stay valid DECODE..WB.
    // Immediate codes: I=0 SHIFT=1 S=2 U=3 B=4 J=5; wb: ALU0 MEM1 PC4 2 IMM3.
    function automatic exp_t decode_fields(input logic [31:0] ins, output bit legal);
        exp_t d;
        logic [2:0] f3;
        d = '0;
        f3 = ins[14:12];
        legal = 1'b1;
        case (ins[6:0])
            7'h33: d.alu_cls = 2'd1;
            7'h13: begin
                d.sext_op = (f3 == 3'd1 || f3 == 3'd5) ? 3'd1 : 3'd0;
                d.alu_src_b = 1'b1; d.alu_cls = 2'd1;
            end
            7'h03: begin d.alu_src_b = 1'b1; d.wb_sel = 2'd1; end
            7'h23: begin d.sext_op = 3'd2; d.alu_src_b = 1'b1; end
            7'h63: begin d.sext_op = 3'd4; d.alu_cls = 2'd2; end
            7'h6F: begin d.sext_op = 3'd5; d.alu_src_a = 1'b1; d.alu_src_b = 1'b1; d.wb_sel = 2'd2; end
            7'h67: begin d.alu_src_b = 1'b1; d.wb_sel = 2'd2; end
            7'h37: begin d.sext_op = 3'd3; d.alu_src_b = 1'b1; d.wb_sel = 2'd3; end
            7'h17: begin d.sext_op = 3'd3; d.alu_src_a = 1'b1; d.alu_src_b = 1'b1; end
            default: legal = 1'b0;
        endcase
        return d;
    endfunction

    // Expected trace for one instruction. fw/mw = wait cycles in FETCH/MEM,
    // br_force < 0 means random branch flag, nhalt = HALT cycles to observe.
    function automatic void build_trace(input logic [31:0] ins, input int fw, input int mw,
                                        input int br_force, input int nhalt);
        cyc_t c;
        exp_t d;
        bit legal;
        logic [6:0] op;
        op = ins[6:0];
        d = decode_fields(ins, legal);
        trace.delete();
        for (int w = 0; w <= fw; w++) begin
            c.e = '0; c.e.state = 3'd0; c.e.mem_req = 1'b1;
            c.rdy = (w == fw); c.e.ir_we = c.rdy; c.br = 1'($urandom_range(0, 1));
            trace.push_back(c);
        end
        c.e = d; c.e.state = 3'd1;
        c.rdy = 1'($urandom_range(0, 1)); c.br = 1'($urandom_range(0, 1));
        trace.push_back(c);
        if (!legal) begin
            for (int h = 0; h < nhalt; h++) begin
                c.e = '0; c.e.state = 3'd5; c.e.halted = 1'b1;
                c.rdy = 1'($urandom_range(0, 1)); c.br = 1'($urandom_range(0, 1));
                trace.push_back(c);
            end
            return;
        end
        c.e = d; c.e.state = 3'd2;
        c.rdy = 1'($urandom_range(0, 1));
        c.br = (br_force < 0) ? 1'($urandom_range(0, 1)) : 1'(br_force);
        if (op == 7'h63) begin
            c.e.pc_we = 1'b1; c.e.npc_op = {1'b0, c.br};
        end
        trace.push_back(c);
        if (op == 7'h63) return;
        if (op == 7'h03 || op == 7'h23) begin
            for (int w = 0; w <= mw; w++) begin
                c.e = d; c.e.state = 3'd3; c.e.mem_req = 1'b1; c.e.mem_sel_data = 1'b1;
                c.e.mem_we = (op == 7'h23);
                c.rdy = (w == mw); c.br = 1'($urandom_range(0, 1));
                c.e.pc_we = (op == 7'h23) && c.rdy;
                trace.push_back(c);
            end
            if (op == 7'h23) return;
        end
        c.e = d; c.e.state = 3'd4; c.e.pc_we = 1'b1;
        c.e.npc_op = (op == 7'h6F) ? 2'd2 : (op == 7'h67) ? 2'd3 : 2'd0;
        c.e.rf_we = (ins[11:7] != 5'd0);
        c.rdy = 1'($urandom_range(0, 1)); c.br = 1'($urandom_range(0, 1));
        trace.push_back(c);
    endfunction

    // Replays up to max_cyc records of the trace (negative = all).
    task automatic run_trace(input string name, input logic [31:0] ins, input int max_cyc);
        int n;
        n = (max_cyc < 0 || max_cyc > trace.size()) ? trace.size() : max_cyc;
        bus.inst = ins;
        for (int i = 0; i < n; i++) begin
            bus.mem_ready = trace[i].rdy;
            bus.br_flag   = trace[i].br;
            @(negedge clk);
            check_vec($sformatf("%s cyc%0d", name, i), observe(), trace[i].e);
            @(posedge clk);
            #1;
        end
        $display("txn %-8s inst=%08h cycles=%0d checks=%0d errors=%0d", name, ins, n, checks, errors);
    endtask

    task automatic do_reset(input string name, input int cycles);
        rst = 1'b1;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s mem_req during rst: got %b required 0", name, bus.mem_req);
        end
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check_vec({name, " state"}, observe(), exp_t'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        $display("txn %-8s reset held %0d cycles checks=%0d errors=%0d", name, cycles, checks, errors);
    endtask

    logic [6:0] legal_ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

    initial begin
        logic [31:0] rnd;
        logic [31:0] ins;
        rst = 1'b1;
        bus.inst = 32'h0;
        bus.mem_ready = 1'b0;
        bus.br_flag = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset("reset", 1);

        // addi x1,x0,5 : 4 cycles, WB rf_we=1 wb_sel=0 pc_we=1 npc_op=0
        build_trace(32'h00500093, 0, 0, -1, 0);
        check_int("len_addi", trace.size(), 4);
        check_int("addi_wb_rfwe", int'(trace[3].e.rf_we), 1);
        check_int("addi_srcb", int'(trace[1].e.alu_src_b), 1);
        run_trace("addi", 32'h00500093, -1);

        // lw with two MEM wait cycles : 7 cycles
        build_trace(32'h0040A103, 0, 2, -1, 0);
        check_int("len_lw", trace.size(), 7);
        check_int("lw_wbsel", int'(trace[6].e.wb_sel), 1);
        run_trace("lw", 32'h0040A103, -1);

        build_trace(32'h0020A423, 0, 0, -1, 0);
        check_int("len_sw", trace.size(), 4);
        check_int("sw_sext", int'(trace[1].e.sext_op), 2);
        run_trace("sw", 32'h0020A423, -1);

        build_trace(32'h00209193, 1, 0, -1, 0);
        check_int("slli_sext", int'(trace[2].e.sext_op), 1);
        run_trace("slli", 32'h00209193, -1);

        build_trace(32'h00000463, 0, 0, 1, 0);
        check_int("len_beq", trace.size(), 3);
        check_int("beq_t_npc", int'(trace[2].e.npc_op), 1);
        run_trace("beq_t", 32'h00000463, -1);
        build_trace(32'h00000463, 0, 0, 0, 0);
        run_trace("beq_nt", 32'h00000463, -1);

        build_trace(32'h010000EF, 0, 0, -1, 0);
        check_int("jal_npc", int'(trace[3].e.npc_op), 2);
        run_trace("jal_x1", 32'h010000EF, -1);
        build_trace(32'h0000006F, 0, 0, -1, 0);
        check_int("jal_x0_rfwe", int'(trace[3].e.rf_we), 0);
        run_trace("jal_x0", 32'h0000006F, -1);

        // Randomized legal instruction stream
        for (int k = 0; k < 80; k++) begin
            rnd = $urandom();
            ins = {rnd[31:7], legal_ops[$urandom_range(0, 8)]};
            build_trace(ins, $urandom_range(0, 2), $urandom_range(0, 3), -1, 0);
            run_trace($sformatf("rnd%0d", k), ins, -1);
        end

        // Illegal instruction parks the core; reset releases it
        build_trace(32'hFFFFFFFF, 0, 0, -1, 10);
        run_trace("illegal", 32'hFFFFFFFF, -1);
        do_reset("rst_halt", 1);

        // Reset while a load stalls in MEM
        build_trace(32'h0040A103, 0, 5, -1, 0);
        run_trace("lw_part", 32'h0040A103, 5);
        do_reset("rst_mem", 2);

        build_trace(32'h00500093, 0, 0, -1, 0);
        run_trace("addi2", 32'h00500093, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
